cmp_seq_ctrl: RTL
=================

Name: cmp_seq_ctrl

Overview:
- Sequencer for the bit-serial magnitude compare of two WIDTH-bit operands.
- Operands are loaded one 4-bit nibble at a time from the switch/nibble bus into internal A and B registers.
- On start, the block walks MSB to LSB through a single one-bit compare stage, one bit per clock, and reports lo/go/eo with a done pulse.
- Sits between the debounced pushbutton/switch front end and the result LEDs; replaces the per-nibble edge-clocked operand registers with a single-clock design.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of 4, range 4..16.
- EARLY_EXIT, 1, when 1 the run terminates at the first differing bit; when 0 it always runs WIDTH bits.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- nib  in  4  nibble data for operand load.
- ld_valid  in  1  load request, single-cycle qualified by ld_ready.
- ld_sel  in  log2(WIDTH/2)  target nibble. Lower half of the codes selects A nibbles 0..WIDTH/4-1, upper half selects B. For WIDTH=8: 0=A[3:0], 1=A[7:4], 2=B[3:0], 3=B[7:4].
- ld_ready  out  1  high when a load is accepted (state IDLE).
- start  in  1  begin a compare; sampled only in IDLE.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when the result becomes valid.
- res_valid  out  1  lo/go/eo hold a valid result.
- lo  out  1  A < B.
- go  out  1  A > B.
- eo  out  1  A == B.
- bit_idx  out  log2(WIDTH)  bit currently being compared (debug).

Behaviour:
- Reset (async, rst_n=0):
  - A=0, B=0, state=IDLE.
  - lo=go=eo=0, res_valid=0, done=0, bit_idx=WIDTH-1.
  - ld_ready=1 after release.
- States are IDLE, RUN and DONE.
- IDLE:
  - ld_ready=1.
  - ld_valid writes nib into the selected nibble at that edge; other nibbles are unchanged.
  - start=1 at edge k moves to RUN and clears res_valid.
  - Accumulator is set to lo=0, go=0, eq=1 and bit_idx=WIDTH-1.
- RUN:
  - Each cycle, one-bit stage inputs are A[bit_idx], B[bit_idx] and the accumulator flags; its outputs are registered into the accumulator.
  - bit_idx decrements by 1 each cycle.
  - Leave to DONE after the compare at bit_idx==0, or, when EARLY_EXIT=1, after the first compare producing lo|go.
- DONE (one cycle):
  - done=1, res_valid=1.
  - lo/go/eo are driven from the accumulator and held until the next accepted start.
  - Next state is IDLE.
- Latency, with start sampled at edge k:
  - EARLY_EXIT=0: done is high in the cycle after edge k+WIDTH+1.
  - EARLY_EXIT=1, first differing bit i (MSB = WIDTH-1): done after edge k+(WIDTH-i)+1.
  - EARLY_EXIT=1, equal operands: done after edge k+WIDTH+1.
- Exactly one of lo/go/eo is 1 whenever res_valid=1.
- Simultaneous load and start in IDLE: both are accepted. The load lands at edge k and the first compare (cycle k+1) uses the new value.
- ld_valid while busy: ld_ready=0; the write is dropped and operands are unchanged.
- start while busy: ignored, not queued.
- Reset mid-RUN: immediate return to IDLE, operands cleared, no done pulse.
- bit_idx never wraps; it is reloaded only on start.

Decomposition:
- Shared package (cmp_pkg):
  - state enum {IDLE, RUN, DONE}.
  - Result flag bit positions LO/GO/EO.
  - Nibble-select code constants.
- Sub-module: the existing one_bit_comparator, instantiated once as the serial bit stage.
- All sequencing, operand registers and the accumulator live in cmp_seq_ctrl.

Test Plan:
1. Load A=0x5A, B=0x5A, then start (EARLY_EXIT=1) -> eo=1, lo=go=0; done 9 cycles after the start edge; res_valid stays 1 until the next start.
2. A=0x80, B=0x7F, start -> go=1; done 2 cycles after start (MSB differs). Same with EARLY_EXIT=0 -> go=1, done after 9 cycles.
3. A=0x12, B=0x13, start -> lo=1; done after 9 cycles (only bit 0 differs).
4. A=0x00, B=0xFF, start, then ld_sel=0, nib=0xF pulsed during RUN -> write dropped (ld_ready=0); result lo=1; a rerun without reloading still gives lo=1.
5. A=0x3C, B=0x3D, start; rst_n pulsed low 3 cycles in -> outputs 0, res_valid=0, no done pulse; a reload and rerun then completes normally.
6. Same-cycle ld_sel=3, nib=0x9 and start with A=0x95, B=0x05 -> B becomes 0x95 before the first compare; eo=1; a second start pulse while busy is ignored (exactly one done pulse).

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude compare sequencer.
// Holds the FSM state type, the result flag layout and the nibble-select code map.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result/accumulator flag bit positions.
  localparam int LO = 0;
  localparam int GO = 1;
  localparam int EO = 2;

  typedef logic [2:0] flags_t;

  localparam flags_t FLAGS_INIT = 3'b100;  // lo=0, go=0, eq=1

  // Nibble-select codes for the default 8-bit build.
  localparam int SEL_A_LO = 0;
  localparam int SEL_A_HI = 1;
  localparam int SEL_B_LO = 2;
  localparam int SEL_B_HI = 3;

  // Generic select code: A nibbles occupy the lower half of the code space, B the upper half.
  function automatic int sel_code(input logic is_b, input int nib_pos, input int nibs);
    return is_b ? (nibs + nib_pos) : nib_pos;
  endfunction

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// Load/start/result bus of the compare sequencer.
// The front end (master) drives operands and start; the sequencer (slave) reports status.
interface cmp_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(WIDTH / 2);
  localparam int IDX_W = $clog2(WIDTH);

  logic [3:0]       nib;
  logic             ld_valid;
  logic [SEL_W-1:0] ld_sel;
  logic             ld_ready;
  logic             start;
  logic             busy;
  logic             done;
  logic             res_valid;
  logic             lo;
  logic             go;
  logic             eo;
  logic [IDX_W-1:0] bit_idx;

  modport master (
    output nib, ld_valid, ld_sel, start,
    input  ld_ready, busy, done, res_valid, lo, go, eo, bit_idx
  );

  modport slave (
    input  nib, ld_valid, ld_sel, start,
    output ld_ready, busy, done, res_valid, lo, go, eo, bit_idx
  );

endinterface

// File: rtl/one_bit_comparator.sv
// One bit of a cascaded magnitude comparator: once a decision (lo/go) has been
// made at a more significant bit it is carried through unchanged.
module one_bit_comparator (
  input  logic a,
  input  logic b,
  input  logic lo_in,
  input  logic go_in,
  input  logic eo_in,
  output logic lo,
  output logic go,
  output logic eo
);

  assign lo = lo_in | (eo_in & ~a &  b);
  assign go = go_in | (eo_in &  a & ~b);
  assign eo = eo_in & ~(a ^ b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Sequencer for a bit-serial MSB-first magnitude compare of two WIDTH-bit operands
// loaded nibble by nibble; reports lo/go/eo with a one-cycle done pulse.
module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input logic          clk,
  input logic          rst_n,
  cmp_seq_ctrl_if.slave bus
);

  localparam int NIBS  = WIDTH / 4;
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  flags_t           acc_q;
  flags_t           stage;
  flags_t           res_q;
  logic             res_valid_q;
  logic             done_q;

  // ---------------------------------------------------------------------------
  // Serial bit stage: operand bits under bit_idx plus the running accumulator.
  // ---------------------------------------------------------------------------
  one_bit_comparator u_bit (
    .a     (a_q[idx_q]),
    .b     (b_q[idx_q]),
    .lo_in (acc_q[LO]),
    .go_in (acc_q[GO]),
    .eo_in (acc_q[EO]),
    .lo    (stage[LO]),
    .go    (stage[GO]),
    .eo    (stage[EO])
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        if (idx_q == '0)                                     state_d = DONE;
        else if ((EARLY_EXIT != 0) && (stage[LO] || stage[GO])) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand registers: writable only while idle; a load and a start in the
  // same cycle both take effect, and the first compare sees the new nibble.
  // ---------------------------------------------------------------------------
  // NOTE: the operands are plain flops (not a RAM), so they take the async
  // reset and come up as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state_q == IDLE && bus.ld_valid) begin
      for (int n = 0; n < NIBS; n++) begin
        if (int'(bus.ld_sel) == sel_code(1'b0, n, NIBS)) a_q[n*4 +: 4] <= bus.nib;
        if (int'(bus.ld_sel) == sel_code(1'b1, n, NIBS)) b_q[n*4 +: 4] <= bus.nib;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator, bit index and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= FLAGS_INIT;
      idx_q       <= IDX_MSB;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          acc_q <= FLAGS_INIT;
          if (bus.start) begin
            idx_q       <= IDX_MSB;
            res_q       <= '0;
            res_valid_q <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= stage;
          // Saturate at bit 0 so the index never wraps to the MSB.
          if (idx_q != '0) idx_q <= idx_q - IDX_W'(1);
        end
        DONE: begin
          res_q       <= acc_q;
          res_valid_q <= 1'b1;
          done_q      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ld_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.res_valid = res_valid_q;
  assign bus.lo        = res_q[LO];
  assign bus.go        = res_q[GO];
  assign bus.eo        = res_q[EO];
  assign bus.bit_idx   = idx_q;

endmodule
